// File: rtl/uart_rx.sv
// 8-N-1 UART receiver with a one-entry valid/ready holding register.
// Optional even parity bit is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int Clock = 50,
  parameter int Baud  = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam int BAUD_DIV = (Clock * 1000000) / Baud;
  localparam int HALF_DIV = BAUD_DIV / 2;
  localparam int CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             frame_err_q;
  logic             rxd_meta_q;
  logic             rxs_q;

  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             overrun_q, overrun_d;

  logic             half_tick;
  logic             bit_tick;
  logic             parity_ok;
  logic             deliver;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q <= 1'b1;
      rxs_q      <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxs_q      <= rxd_meta_q;
    end
  end

  assign half_tick = (cnt_q == CNT_HALF);
  assign bit_tick  = (cnt_q == CNT_LAST);

`ifdef UART_RX_PARITY_EN
  logic par_bit_q;
  logic parity_err_q;

  assign parity_ok  = ~(^{shift_q, par_bit_q});
  assign parity_err = parity_err_q;
`else
  assign parity_ok  = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!rxs_q) begin
            state_q <= S_START;
          end
        end

        S_START: begin
          if (half_tick) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            // A start bit that is high again at mid-bit was a glitch.
            state_q   <= rxs_q ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (bit_tick) begin
            cnt_q     <= '0;
            shift_q   <= {rxs_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (bit_tick) begin
            cnt_q     <= '0;
            par_bit_q <= rxs_q;
            state_q   <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`endif

        S_STOP: begin
          if (bit_tick) begin
            cnt_q <= '0;
            if (rxs_q) begin
              state_q <= S_IDLE;
`ifdef UART_RX_PARITY_EN
              parity_err_q <= ~parity_ok;
`endif
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_WAIT_HIGH: begin
          cnt_q <= '0;
          if (rxs_q) begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // A byte is handed over only on a clean stop bit with matching parity.
  assign deliver = (state_q == S_STOP) && bit_tick && rxs_q && parity_ok;

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: expected events are queued at stimulus time
// and a monitor pops and compares them as the receiver produces outputs.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int BIT_T   = 10;
  localparam int EV_DATA = 1;
  localparam int EV_FERR = 2;
  localparam int EV_OVR  = 3;
  localparam int EV_PERR = 4;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  bit hold_full = 1'b0;
  bit mon_prev_valid = 1'b0;

  uart_rx #(.Clock(1), .Baud(100000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  // Expected outcome of one frame, encoded as kind*256 + data.
  function automatic int model(input logic [7:0] b, input bit stop, input bit par_bit,
                               input bit full, input bit ready);
    if (!stop) return EV_FERR << 8;
    if (PAR_EN && ((^b) != par_bit)) return EV_PERR << 8;
    if (full && !ready) return EV_OVR << 8;
    return (EV_DATA << 8) | int'(b);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_event(input int kind, input logic [7:0] data);
    int got;
    int exp;
    got = (kind << 8) | int'(data);
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got kind=%0d data=0x%02h expected none", kind, data);
    end else begin
      exp = exp_q.pop_front();
      if (got != exp) begin
        failures++;
        $display("FAIL event: got kind=%0d data=0x%02h expected kind=%0d data=0x%02h",
                 kind, data, exp >> 8, exp & 8'hff);
      end else begin
        $display("event kind=%0d data=0x%02h ok", kind, data);
      end
    end
  endtask

  // Monitor samples just after each rising edge; inputs only change on falling edges.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mon_prev_valid = 1'b0;
      end else begin
        if (rx_valid && (!mon_prev_valid || rx_ready)) check_event(EV_DATA, rx_data);
        if (frame_err)  check_event(EV_FERR, 8'h00);
        if (overrun)    check_event(EV_OVR, 8'h00);
        if (parity_err) check_event(EV_PERR, 8'h00);
        mon_prev_valid = rx_valid;
      end
    end
  end

  task automatic drive_frame(input logic [7:0] b, input bit stop, input bit par_bit,
                             input int low_extra);
    rxd = 1'b0;
    repeat (BIT_T) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT_T) @(negedge clk);
    end
    if (PAR_EN) begin
      rxd = par_bit;
      repeat (BIT_T) @(negedge clk);
    end
    rxd = stop;
    repeat (BIT_T) @(negedge clk);
    if (!stop) repeat (low_extra) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input bit stop, input bit par_bit, input int low_extra);
    int ev;
    ev = model(b, stop, par_bit, hold_full, rx_ready);
    exp_q.push_back(ev);
    if ((ev >> 8) == EV_DATA) hold_full = !rx_ready;
    else if (rx_ready) hold_full = 1'b0;
    drive_frame(b, stop, par_bit, low_extra);
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rx_data"}, 32'(rx_data), 32'h0);
    chk({tag, "_rx_valid"}, 32'(rx_valid), 32'h0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    chk({tag, "_overrun"}, 32'(overrun), 32'h0);
    chk({tag, "_parity_err"}, 32'(parity_err), 32'h0);
  endtask

  initial begin
    logic [7:0] b;
    bit stop;
    bit par;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    gap(5);

    send(8'h55, 1'b1, ^8'h55, 0);
    gap(10);

    rxd = 1'b0;
    gap(3);
    rxd = 1'b1;
    gap(20);
    send(8'h3C, 1'b1, ^8'h3C, 0);
    gap(10);

    send(8'hA3, 1'b0, ^8'hA3, 40);
    gap(10);
    send(8'h81, 1'b1, ^8'h81, 0);
    gap(10);

    rx_ready = 1'b0;
    send(8'h12, 1'b1, ^8'h12, 0);
    gap(5);
    send(8'h34, 1'b1, ^8'h34, 0);
    gap(5);
    chk("ovr_hold_data", 32'(rx_data), 32'h12);
    chk("ovr_hold_valid", 32'(rx_valid), 32'h1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    hold_full = 1'b0;
    chk("ovr_accept_valid", 32'(rx_valid), 32'h0);
    chk("ovr_accept_data", 32'(rx_data), 32'h12);
    gap(5);

    send(8'h5A, 1'b1, ^8'h5A, 0);
    gap(5);
    chk("prerst_valid", 32'(rx_valid), 32'h1);
    fork
      drive_frame(8'hFF, 1'b1, ^8'hFF, 0);
      begin
        gap(45);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        gap(2);
        rst_n = 1'b1;
      end
    join
    hold_full = 1'b0;
    rx_ready = 1'b1;
    gap(10);
    send(8'hC7, 1'b1, ^8'hC7, 0);
    gap(10);

    if (PAR_EN) begin
      send(8'h01, 1'b1, 1'b0, 0);
      gap(10);
      send(8'h01, 1'b1, 1'b1, 0);
      gap(10);
    end

    for (int n = 0; n < 24; n++) begin
      b = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      par = (^b) ^ (PAR_EN && ($urandom_range(0, 4) == 0));
      rx_ready = ($urandom_range(0, 3) != 0);
      send(b, stop, par, int'($urandom_range(0, 30)));
      gap(int'($urandom_range(2, 15)));
    end
    rx_ready = 1'b1;

    gap(30);
    chk("drain_pending", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
